// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/divider_32bit_seq_if.sv
// Start/done handshake and operand/result bus of the divider.
interface divider_32bit_seq_if #(
  parameter int W = divider_pkg::WIDTH
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/divider_32bit_step.sv
// One restoring shift-subtract iteration on the {remainder, quotient} register.
module divider_32bit_step
  import divider_pkg::*;
#(
  parameter int WIDTH = divider_pkg::WIDTH
) (
  input  logic [2*WIDTH-1:0] sreg,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] sreg_next
);

  // Upper half after the left shift, keeping the bit shifted out of the top;
  // without it a partial remainder near 2^WIDTH would be truncated.
  logic [WIDTH:0]   partial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign partial = sreg[2*WIDTH-1:WIDTH-1];
  assign fits    = (partial >= {1'b0, divisor});
  // When the divisor fits, the difference is below the divisor, so WIDTH bits suffice.
  assign diff    = partial[WIDTH-1:0] - divisor;

  // Subtract and set a quotient bit, or restore and shift in a zero.
  always_comb begin
    sreg_next = {sreg[2*WIDTH-2:0], 1'b0};
    if (fits) begin
      sreg_next = {diff, sreg[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider_32bit_seq.sv
// Sequential unsigned restoring divider: control FSM, iteration counter and
// result registers around the combinational step.
//
// state | meaning
// IDLE  | waiting for start; last result held on the outputs
// RUN   | one shift-subtract iteration per clock, WIDTH iterations
// DONE  | final register state; results and done register on the way out
module divider_32bit_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = divider_pkg::WIDTH,
  parameter int CNT_W = divider_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  divider_32bit_seq_if.slave bus
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] sreg_q, sreg_step;
  logic [WIDTH-1:0]   dvsr_q;
  logic [WIDTH-1:0]   quot_q, rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q, dz_q;
  logic               accept, last_iter;

  // done_q high means the result is being presented; a start then is ignored.
  assign accept    = bus.start && (state_q == IDLE) && !done_q;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  divider_32bit_step #(.WIDTH(WIDTH)) u_step (
    .sreg      (sreg_q),
    .divisor   (dvsr_q),
    .sreg_next (sreg_step)
  );

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus.divisor == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (accept) begin
        sreg_q <= {{WIDTH{1'b0}}, bus.dividend};
        dvsr_q <= bus.divisor;
        cnt_q  <= '0;
        dz_q   <= 1'b0;
      end else if (state_q == RUN) begin
        sreg_q <= sreg_step;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (state_q == DONE) begin
        // A zero divisor skipped RUN, so the lower half still holds the dividend.
        if (dvsr_q == '0) begin
          quot_q <= '1;
          rem_q  <= sreg_q[WIDTH-1:0];
          dz_q   <= 1'b1;
        end else begin
          quot_q <= sreg_q[WIDTH-1:0];
          rem_q  <= sreg_q[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.busy        = (state_q != IDLE) || done_q;

endmodule
